mc_maindec: RTL and testbench



---
 rtl/mc_maindec.sv | 180 ++++++++++++++++++
 tb/tb_mc_maindec.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: state register plus Moore decode of datapath controls.
// Optional `MC_MAINDEC_MEMREADY_EN adds a memready handshake that stalls FETCH, MEMRD and MEMWR.
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
`ifdef MC_MAINDEC_MEMREADY_EN
  input  logic       memready,
`endif
  output logic [2:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;
  state_t w_next;
  logic   w_mem_ok;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;

`ifdef MC_MAINDEC_MEMREADY_EN
  assign w_mem_ok = memready;
`else
  assign w_mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = S_FETCH;
    illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_BNE:       w_next = S_BNEEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_ORI:       w_next = S_ORIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:   w_next = w_mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_IMMWB;
      S_ORIEX:   w_next = S_IMMWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore decode; write enables are raw here and gated by reset below.
  always_comb begin
    aluop      = 3'b000;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = w_mem_ok;
        w_pcwrite = w_mem_ok;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 3'b100;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = (r_state == S_BEQEX) ? 3'b110 : 3'b111;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX, S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (r_state == S_ORIEX) begin
          aluop   = 3'b001;
          zeroext = 1'b1;
        end
      end
      S_IMMWB:   w_regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Asynchronous reset must kill every write in the same cycle it is asserted.
  assign irwrite  = w_irwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: per-cycle stimulus and expected control vectors are queued, then compared.
module tb_mc_maindec;
  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mrdy;
  logic [2:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, illegal;
  logic [3:0] state;

  mc_maindec dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
`ifdef MC_MAINDEC_MEMREADY_EN
    .memready(mrdy),
`endif
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
    .pcsrc(pcsrc), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .pcen(pcen),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

  // {state, aluop, alusrca, alusrcb, zeroext, pcsrc, iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, illegal}
  localparam logic [20:0] E_RST    = {4'd0,  3'b000, 1'b0, 2'b01, 1'b0, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_FETCH  = {4'd0,  3'b000, 1'b0, 2'b01, 1'b0, 2'b00, 8'b0100_0010};
  localparam logic [20:0] E_DEC    = {4'd1,  3'b000, 1'b0, 2'b11, 1'b0, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_DECILL = {4'd1,  3'b000, 1'b0, 2'b11, 1'b0, 2'b00, 8'b0000_0001};
  localparam logic [20:0] E_MEMADR = {4'd2,  3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_MEMRD  = {4'd3,  3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b1000_0000};
  localparam logic [20:0] E_MEMWB  = {4'd4,  3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0001_0100};
  localparam logic [20:0] E_MEMWR  = {4'd5,  3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b1010_0000};
  localparam logic [20:0] E_RTYPE  = {4'd6,  3'b100, 1'b1, 2'b00, 1'b0, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_ALUWB  = {4'd7,  3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0001_1000};
  localparam logic [20:0] E_ADDI   = {4'd10, 3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_ORI    = {4'd11, 3'b001, 1'b1, 2'b10, 1'b1, 2'b00, 8'b0000_0000};
  localparam logic [20:0] E_IMMWB  = {4'd12, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0001_0000};
  localparam logic [20:0] E_JEX    = {4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b10, 8'b0000_0010};

  function automatic logic [20:0] e_beq(input logic z);
    return {4'd8, 3'b110, 1'b1, 2'b00, 1'b0, 2'b01, 6'b0, z, 1'b0};
  endfunction
  function automatic logic [20:0] e_bne(input logic z);
    return {4'd9, 3'b111, 1'b1, 2'b00, 1'b0, 2'b01, 6'b0, z, 1'b0};
  endfunction
  function automatic logic [8:0] s(input logic r, input logic [5:0] o, input logic z, input logic m);
    return {r, o, z, m};
  endfunction

  wire [20:0] w_obs = {state, aluop, alusrca, alusrcb, zeroext, pcsrc,
                       iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, illegal};

  int checks = 0;
  int errors = 0;
  logic [8:0]  sq[$];
  logic [20:0] sb[$];

  task automatic test_reset();
    logic [20:0] e;
    for (int i = 0; i < 3; i++) begin
      sq.push_back(s(1'b1, OP_LW, 1'b1, 1'b1)); sb.push_back(E_RST);
    end
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL reset obs=%h exp=%h state=%0d", w_obs, e, state);
      end
    end
  endtask

  task automatic test_lw_sw();
    logic [20:0] e;
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_MEMRD);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_MEMWB);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_SW, 1, 1)); sb.push_back(E_MEMWR);
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL lw_sw obs=%h exp=%h state=%0d", w_obs, e, state);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    for (int z = 1; z >= 0; z--) begin
      sq.push_back(s(0, OP_BNE, 0, 1));         sb.push_back(E_FETCH);
      sq.push_back(s(0, OP_BNE, 1, 1));         sb.push_back(E_DEC);
      sq.push_back(s(0, OP_BNE, z[0], 1));      sb.push_back(e_bne(z[0]));
      sq.push_back(s(0, OP_BEQ, 1, 1));         sb.push_back(E_FETCH);
      sq.push_back(s(0, OP_BEQ, 1, 1));         sb.push_back(E_DEC);
      sq.push_back(s(0, OP_BEQ, z[0], 1));      sb.push_back(e_beq(z[0]));
    end
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL branch obs=%h exp=%h state=%0d zero=%b", w_obs, e, state, zero);
      end
    end
  endtask

  task automatic test_imm_jump_illegal();
    logic [20:0] e;
    sq.push_back(s(0, OP_ORI, 0, 1));  sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_ORI, 0, 1));  sb.push_back(E_DEC);
    sq.push_back(s(0, OP_ORI, 0, 1));  sb.push_back(E_ORI);
    sq.push_back(s(0, OP_ORI, 0, 1));  sb.push_back(E_IMMWB);
    sq.push_back(s(0, OP_ADDI, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_ADDI, 0, 1)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_ADDI, 0, 1)); sb.push_back(E_ADDI);
    sq.push_back(s(0, OP_ADDI, 0, 1)); sb.push_back(E_IMMWB);
    sq.push_back(s(0, OP_J, 1, 1));    sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_J, 1, 1));    sb.push_back(E_DEC);
    sq.push_back(s(0, OP_J, 0, 1));    sb.push_back(E_JEX);
    sq.push_back(s(0, OP_BAD, 0, 1));  sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_BAD, 0, 1));  sb.push_back(E_DECILL);
    sq.push_back(s(0, 6'b000001, 1, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, 6'b000001, 1, 1)); sb.push_back(E_DECILL);
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL imm_j_ill obs=%h exp=%h state=%0d op=%b", w_obs, e, state, op);
      end
    end
  endtask

  // op changes outside DECODE/MEMADR must not disturb the sequence.
  task automatic test_back_to_back();
    logic [20:0] e;
    sq.push_back(s(0, OP_R, 0, 1));    sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_R, 0, 1));    sb.push_back(E_DEC);
    sq.push_back(s(0, OP_BAD, 1, 1));  sb.push_back(E_RTYPE);
    sq.push_back(s(0, OP_J, 1, 1));    sb.push_back(E_ALUWB);
    sq.push_back(s(0, OP_LW, 0, 1));   sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_LW, 0, 1));   sb.push_back(E_DEC);
    sq.push_back(s(0, OP_LW, 0, 1));   sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_SW, 1, 1));   sb.push_back(E_MEMRD);
    sq.push_back(s(0, OP_BAD, 1, 1));  sb.push_back(E_MEMWB);
    sq.push_back(s(0, OP_BEQ, 1, 1));  sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_BEQ, 0, 1));  sb.push_back(E_DEC);
    sq.push_back(s(0, OP_ORI, 1, 1));  sb.push_back(e_beq(1'b1));
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL b2b obs=%h exp=%h state=%0d", w_obs, e, state);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] e;
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_MEMWR);
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL async_pre obs=%h exp=%h state=%0d", w_obs, e, state);
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0) begin
      errors++;
      $display("FAIL async_memwrite got=%b want=0", memwrite);
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL async_state got=%0d want=0", state);
    end
    sq.push_back(s(1, OP_SW, 0, 1)); sb.push_back(E_RST);
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL async_hold obs=%h exp=%h state=%0d", w_obs, e, state);
      end
    end
  endtask

`ifdef MC_MAINDEC_MEMREADY_EN
  task automatic test_memready();
    logic [20:0] e;
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_RST);
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_RST);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_MEMRD);
    sq.push_back(s(0, OP_LW, 0, 1)); sb.push_back(E_MEMRD);
    sq.push_back(s(0, OP_LW, 0, 0)); sb.push_back(E_MEMWB);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_FETCH);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_DEC);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_MEMADR);
    sq.push_back(s(0, OP_SW, 0, 0)); sb.push_back(E_MEMWR);
    sq.push_back(s(0, OP_SW, 0, 1)); sb.push_back(E_MEMWR);
    sq.push_back(s(0, OP_J, 0, 1));  sb.push_back(E_FETCH);
    while (sq.size() > 0) begin
      @(negedge clk);
      {reset, op, zero, mrdy} = sq.pop_front();
      #2;
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        errors++;
        $display("FAIL memready obs=%h exp=%h state=%0d mrdy=%b", w_obs, e, state, mrdy);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    op    = 6'd0;
    zero  = 1'b0;
    mrdy  = 1'b1;
    test_reset();
    test_lw_sw();
    test_branch();
    test_imm_jump_illegal();
    test_back_to_back();
    test_async_reset();
`ifdef MC_MAINDEC_MEMREADY_EN
    test_memready();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
